mdu_issuer: RTL and testbench
=============================

Name: mdu_issuer

Overview:
- Pipeline-side initiator for the multiply/divide unit. It sits in the E stage between decode and the MDU.
- Accepts one MDU instruction at a time from D over a valid/ready handshake, registers its operands, and drives the MDU command strobes for exactly one cycle.
- Mirrors the MDU's fixed latency with its own countdown and back-pressures D (stall) until the MDU can take a new command.
- Honours the exception flush Req exactly as the MDU does: Req-cycle commands are dropped and the countdown is frozen.

Parameters:
- MULT_LAT, 5, countdown loaded for MULT/MULTU; must equal the MDU multiply latency.
- DIV_LAT, 10, countdown loaded for DIV/DIVU; must equal the MDU divide latency.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Req  in  1  exception/interrupt flush; commands in this cycle are void
- InValid  in  1  D stage presents an MDU instruction
- InOp  in  3  instruction class (package encoding)
- InSrcA  in  32  rs value
- InSrcB  in  32  rt value
- InReady  out  1  instruction accepted this cycle
- Stall  out  1  InValid && !InReady
- Start  out  1  one-cycle MDU start pulse
- MDUOp  out  4  0=mult, 1=multu, 2=div, 3=divu
- HIWrite  out  1  one-cycle mthi strobe
- LOWrite  out  1  one-cycle mtlo strobe
- HIRead  out  1  mfhi select
- LORead  out  1  mflo select
- SrcA  out  32  registered operand A
- SrcB  out  32  registered operand B
- RdValid  out  1  MDU Result is valid for mfhi/mflo this cycle
- Busy  in  1  MDU busy (Start || count != 0)
- ProtoErr  out  1  sticky protocol-mismatch flag (optional feature)

Behaviour:
- States: IDLE, ISSUE, WAIT. All outputs reset to 0, state resets to IDLE, count resets to 0. Reset mid-operation discards everything; no strobe is emitted in the cycle after reset.
- InReady = (state==IDLE) && !Busy && !Req.
- Acceptance (InValid && InReady): latch InOp, InSrcA and InSrcB into the command registers, then go to ISSUE.
- ISSUE, exactly one cycle. Drive from the latched op: Start+MDUOp for MULT..DIVU, HIWrite for MTHI, LOWrite for MTLO, HIRead+RdValid for MFHI, LORead+RdValid for MFLO. Only one strobe is ever high. InReady=0.
- ISSUE exit:
  - Req=1: the MDU ignores the command. Go to IDLE, count=0, RdValid forced to 0.
  - MULT/MULTU: go to WAIT, count=MULT_LAT.
  - DIV/DIVU: go to WAIT, count=DIV_LAT.
  - All other ops: go to IDLE.
- WAIT: all strobes are 0 and InReady=0. Every MDU op is blocked, including mthi/mtlo/mfhi/mflo.
  - Req=1: count frozen (it matches the MDU freeze).
  - Otherwise count decrements.
  - At count==1 && !Req: go to IDLE.
  - The next instruction is accepted in the cycle the MDU drops Busy. Multiply start-to-accept is 6 cycles; divide is 11.
- SrcA/SrcB hold their value until the next acceptance.
- Req asserted in IDLE: nothing is accepted; Stall follows InValid.
- InOp value NONE, or an undefined encoding, is accepted and retired in ISSUE with no strobe.

Optional Feature:
- Macro MDU_CHECK_EN.
- Defined: expected = (ISSUE && op is mult/div && !Req) || WAIT. ProtoErr sets when Busy != expected (ISSUE cycle excluded for non-mult/div ops) and clears only on reset.
- Not defined: ProtoErr is tied to 0 and no checker logic is generated.

Decomposition:
- Shared package mdu_pkg holds:
  - op-class encoding MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7 (NONE shares 7 only behind a separate valid; use InValid).
  - MDUOp codes 0-3.
  - State encoding.
  - MULT_LAT/DIV_LAT defaults.
- One natural sub-module: mdu_lat_counter (loadable, freezable down-counter with a "last" flag).

Test Plan:
- MULT, InSrcA=-3, InSrcB=7 accepted at cycle 0: Start=1 with MDUOp=0 at cycle 1; Stall held through cycle 6; next op accepted at cycle 7 while MDU Busy=0; LO reads -21.
- DIVU 100/7: Start at cycle 1, ready again at cycle 12; MFLO then gives RdValid=1, LORead=1, Result 14; MFHI gives 2.
- MULT issue with Req=1 in the ISSUE cycle: no WAIT; InReady=1 on the next cycle once Req=0; ProtoErr stays 0.
- DIV in WAIT with Req high for 3 cycles mid-count: completion slips by exactly 3 cycles.
- MTHI 0xDEADBEEF, then MFHI back-to-back: HIWrite pulse of exactly 1 cycle, then MFHI returns 0xDEADBEEF; no Start is ever emitted.
- reset pulsed during WAIT of a DIV: all outputs 0 on the next cycle, state IDLE; with MDU_CHECK_EN, force Busy=1 in IDLE and ProtoErr goes to 1 and stays there.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and latency defaults for the MDU issue path
package mdu_pkg;

  // Instruction class presented by decode; NONE aliases MFLO and is only
  // meaningful together with InValid.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;
  localparam logic [2:0] OP_NONE  = 3'd7;

  // MDU start opcodes
  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Multiply and divide occupy the low half of the op space
  function automatic logic is_muldiv(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/mdu_issuer_if.sv
// rtl/mdu_issuer_if.sv - decode-to-issuer instruction handshake
interface mdu_issuer_if;
  logic        InValid;
  logic [2:0]  InOp;
  logic [31:0] InSrcA;
  logic [31:0] InSrcB;
  logic        InReady;
  logic        Stall;

  modport master (output InValid, InOp, InSrcA, InSrcB, input InReady, Stall);
  modport slave  (input InValid, InOp, InSrcA, InSrcB, output InReady, Stall);
endinterface

// File: rtl/mdu_lat_counter.sv
// rtl/mdu_lat_counter.sv - loadable, freezable down-counter mirroring MDU latency
module mdu_lat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_last
);

  logic [CW-1:0] r_count;

  // Load wins over decrement; decrement stops at zero and is gated by the caller for freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == CW'(1));

endmodule

// File: rtl/mdu_issuer.sv
// rtl/mdu_issuer.sv - E-stage MDU command issuer; optional checker under MDU_CHECK_EN
module mdu_issuer
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Req,
  mdu_issuer_if.slave        d,
  output logic               Start,
  output logic [3:0]         MDUOp,
  output logic               HIWrite,
  output logic               LOWrite,
  output logic               HIRead,
  output logic               LORead,
  output logic [31:0]        SrcA,
  output logic [31:0]        SrcB,
  output logic               RdValid,
  input  logic               Busy,
  output logic               ProtoErr
);

  localparam int CW = 8;

  state_e      r_state;
  logic [2:0]  r_op;
  logic        r_start, r_hiw, r_low, r_hir, r_lor, r_rdv;
  logic [3:0]  r_mduop;
  logic [31:0] r_srca, r_srcb;

  logic w_ready, w_accept, w_load, w_dec, w_last;

  assign w_ready  = (r_state == ST_IDLE) && !Busy && !Req;
  assign w_accept = d.InValid && w_ready;
  assign d.InReady = w_ready;
  assign d.Stall   = d.InValid && !w_ready;

  // Countdown is armed only when the MDU actually takes the command
  assign w_load = (r_state == ST_ISSUE) && !Req && is_muldiv(r_op);
  assign w_dec  = (r_state == ST_WAIT) && !Req;

  mdu_lat_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (r_op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT)),
    .i_dec      (w_dec),
    .o_last     (w_last)
  );

  // Issue FSM: strobes are registered on acceptance so they live exactly in the ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_start <= 1'b0;
      r_hiw   <= 1'b0;
      r_low   <= 1'b0;
      r_hir   <= 1'b0;
      r_lor   <= 1'b0;
      r_rdv   <= 1'b0;
      r_mduop <= '0;
      r_srca  <= '0;
      r_srcb  <= '0;
    end else begin
      r_start <= 1'b0;
      r_hiw   <= 1'b0;
      r_low   <= 1'b0;
      r_hir   <= 1'b0;
      r_lor   <= 1'b0;
      r_rdv   <= 1'b0;
      r_mduop <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= d.InOp;
            r_srca  <= d.InSrcA;
            r_srcb  <= d.InSrcB;
            r_state <= ST_ISSUE;
            case (d.InOp)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_start <= 1'b1;
                r_mduop <= {2'b00, d.InOp[1:0]};
              end
              OP_MTHI: r_hiw <= 1'b1;
              OP_MTLO: r_low <= 1'b1;
              OP_MFHI: begin
                r_hir <= 1'b1;
                r_rdv <= 1'b1;
              end
              OP_MFLO: begin
                r_lor <= 1'b1;
                r_rdv <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          if (Req)                  r_state <= ST_IDLE;
          else if (is_muldiv(r_op)) r_state <= ST_WAIT;
          else                      r_state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (w_last && !Req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Start   = r_start;
  assign MDUOp   = r_mduop;
  assign HIWrite = r_hiw;
  assign LOWrite = r_low;
  assign HIRead  = r_hir;
  assign LORead  = r_lor;
  assign SrcA    = r_srca;
  assign SrcB    = r_srcb;
  // A flushed read must not be consumed downstream
  assign RdValid = r_rdv && !Req;

`ifdef MDU_CHECK_EN
  logic w_expected, w_check, r_proto_err;

  assign w_expected = ((r_state == ST_ISSUE) && is_muldiv(r_op) && !Req) || (r_state == ST_WAIT);
  assign w_check    = !((r_state == ST_ISSUE) && !is_muldiv(r_op));

  // Sticky flag: our view of MDU occupancy disagreed with the MDU's Busy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if (w_check && (Busy != w_expected)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign ProtoErr = r_proto_err;
`else
  assign ProtoErr = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_issuer.sv
// tb/tb_mdu_issuer.sv - randomized self-checking bench for mdu_issuer
module tb_mdu_issuer;
  import mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset, Req;
  logic Start, HIWrite, LOWrite, HIRead, LORead, RdValid, Busy, ProtoErr;
  logic [3:0]  MDUOp;
  logic [31:0] SrcA, SrcB;

  always #5 clk = ~clk;

  mdu_issuer_if d_if ();

  mdu_issuer #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .Req(Req), .d(d_if.slave),
    .Start(Start), .MDUOp(MDUOp), .HIWrite(HIWrite), .LOWrite(LOWrite),
    .HIRead(HIRead), .LORead(LORead), .SrcA(SrcA), .SrcB(SrcB),
    .RdValid(RdValid), .Busy(Busy), .ProtoErr(ProtoErr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // HI/LO result arithmetic for one architectural MDU operation
  function automatic logic [63:0] mdu_math(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: r = {32'(sa % sb), 32'(sa / sb)};
      3'd3: r = {a % b, a / b};
      3'd4: r = {a, lo};
      3'd5: r = {hi, a};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  // Behavioural MDU: fixed latency, frozen and deaf while Req is high
  int          m_cnt;
  logic [31:0] m_hi, m_lo;
  logic        force_busy;
  logic [31:0] result;

  assign Busy   = force_busy || (Start && !Req) || (m_cnt != 0);
  assign result = HIRead ? m_hi : m_lo;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (!Req) begin
      if (Start) begin
        m_cnt <= MDUOp[1] ? DL : ML;
        {m_hi, m_lo} <= mdu_math({1'b0, MDUOp[1:0]}, SrcA, SrcB, m_hi, m_lo);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
      if (HIWrite) m_hi <= SrcA;
      if (LOWrite) m_lo <= SrcA;
    end
  end

  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req_issue, input int req_off, input int req_len);
    int exp_gap, k;
    logic md, got_ready;
    logic [5:0] exp_strb;
    md = (op < 3'd4);
    // present and expect acceptance
    @(posedge clk); #1;
    d_if.InValid = 1'b1; d_if.InOp = op; d_if.InSrcA = a; d_if.InSrcB = b; Req = 1'b0;
    @(negedge clk);
    check_eq("accept_ready", 64'(d_if.InReady), 64'(1));
    check_eq("accept_stall", 64'(d_if.Stall), 64'(0));
    // ISSUE cycle
    @(posedge clk); #1;
    d_if.InValid = 1'b0; Req = req_issue;
    @(negedge clk);
    exp_strb = {md, op == 3'd4, op == 3'd5, op == 3'd6, op == 3'd7, (op >= 3'd6) && !req_issue};
    check_eq("issue_strobes", 64'({Start, HIWrite, LOWrite, HIRead, LORead, RdValid}), 64'(exp_strb));
    check_eq("issue_mduop", 64'(MDUOp), md ? 64'(op) : 64'(0));
    check_eq("issue_src", {SrcA, SrcB}, {a, b});
    check_eq("issue_not_ready", 64'(d_if.InReady), 64'(0));
    if ((op >= 3'd6) && !req_issue)
      check_eq("read_data", 64'(result), 64'((op == 3'd6) ? ref_hi : ref_lo));
    if (!req_issue) {ref_hi, ref_lo} = mdu_math(op, a, b, ref_hi, ref_lo);
    exp_gap = (md && !req_issue) ? ((op[1] ? DL : ML) + 2 + req_len) : 2;
    // wait for the next acceptance opportunity
    k = 2;
    got_ready = 1'b0;
    while (!got_ready && k < 200) begin
      @(posedge clk); #1;
      d_if.InValid = (k < exp_gap) ? 1'($urandom_range(0, 1)) : 1'b0;
      Req = md && !req_issue && (k - 2 >= req_off) && (k - 2 < req_off + req_len);
      @(negedge clk);
      if (d_if.InReady) begin
        got_ready = 1'b1;
      end else begin
        check_eq("wait_stall", 64'(d_if.Stall), 64'(d_if.InValid));
        check_eq("wait_strobes", 64'({Start, HIWrite, LOWrite, HIRead, LORead, RdValid}), 64'(0));
        k++;
      end
    end
    check_eq("ready_gap", 64'(k), 64'(exp_gap));
    d_if.InValid = 1'b0;
    Req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; Req = 1'b0; force_busy = 1'b0;
    d_if.InValid = 1'b0; d_if.InOp = '0; d_if.InSrcA = '0; d_if.InSrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_outputs", 64'({Start, HIWrite, LOWrite, HIRead, LORead, RdValid, MDUOp, ProtoErr}), 64'(0));
    check_eq("reset_src", {SrcA, SrcB}, 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // directed scenarios
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 0);
    run_op(OP_MFLO, 32'd0, 32'd0, 1'b0, 0, 0);
    check_eq("mult_lo_ref", 64'(ref_lo), 64'(32'hFFFF_FFEB));
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 0, 0);
    run_op(OP_MFLO, 32'd0, 32'd0, 1'b0, 0, 0);
    run_op(OP_MFHI, 32'd0, 32'd0, 1'b0, 0, 0);
    run_op(OP_MULT, 32'd5, 32'd6, 1'b1, 0, 0);
    check_eq("flush_protoerr", 64'(ProtoErr), 64'(0));
    run_op(OP_DIV, 32'hFFFF_FFCE, 32'd3, 1'b0, 3, 3);
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 0);
    run_op(OP_MFHI, 32'd0, 32'd0, 1'b0, 0, 0);

    // Req in IDLE blocks acceptance
    @(posedge clk); #1;
    d_if.InValid = 1'b1; d_if.InOp = OP_MTLO; Req = 1'b1;
    @(negedge clk);
    check_eq("idle_req_ready", 64'(d_if.InReady), 64'(0));
    check_eq("idle_req_stall", 64'(d_if.Stall), 64'(1));
    @(posedge clk); #1;
    d_if.InValid = 1'b0; Req = 1'b0;
    @(negedge clk);
    check_eq("idle_req_nostrobe", 64'({Start, HIWrite, LOWrite, HIRead, LORead}), 64'(0));

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (op == OP_DIV || op == OP_DIVU) begin
        if (b == 32'd0) b = 32'd1;
        if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      end
      run_op(op, a, b, ($urandom_range(0, 5) == 0), $urandom_range(0, (op[1] ? DL : ML) - 2), $urandom_range(0, 3));
    end
    check_eq("traffic_protoerr", 64'(ProtoErr), 64'(0));

    // reset in the middle of a divide
    @(posedge clk); #1;
    d_if.InValid = 1'b1; d_if.InOp = OP_DIV; d_if.InSrcA = 32'd1000; d_if.InSrcB = 32'd3;
    @(posedge clk); #1;
    d_if.InValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_hi = '0;
    ref_lo = '0;
    @(negedge clk);
    check_eq("rst_mid_outputs", 64'({Start, HIWrite, LOWrite, HIRead, LORead, RdValid, MDUOp, ProtoErr}), 64'(0));
    check_eq("rst_mid_src", {SrcA, SrcB}, 64'(0));
    check_eq("rst_mid_idle", 64'(d_if.InReady), 64'(1));
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1, 2);
    run_op(OP_MFHI, 32'd0, 32'd0, 1'b0, 0, 0);

    // MDU claims busy while the issuer is idle
    @(posedge clk); #1;
    force_busy = 1'b1;
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk);
`ifdef MDU_CHECK_EN
    check_eq("protoerr_set", 64'(ProtoErr), 64'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("protoerr_sticky", 64'(ProtoErr), 64'(1));
`else
    check_eq("protoerr_off", 64'(ProtoErr), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("protoerr_off_hold", 64'(ProtoErr), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
